// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU controller, the 1-bit slice and the bench.
package alu_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} alu_ser_state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Bit-pair bus between the serial controller (master) and one 1-bit ALU slice (slave).
interface alu_serial_ctrl_if;

    logic       alu_op1;
    logic       alu_op2;
    logic       alu_cin;
    logic [2:0] alu_opsel;
    logic       alu_mode;
    logic       alu_result;
    logic       alu_cout;

    modport master (
        output alu_op1, alu_op2, alu_cin, alu_opsel, alu_mode,
        input  alu_result, alu_cout
    );

    modport slave (
        input  alu_op1, alu_op2, alu_cin, alu_opsel, alu_mode,
        output alu_result, alu_cout
    );

endinterface

// File: rtl/alu_1bit.sv
// Combinational 1-bit ALU slice: full adder (SUB inverts op2) in arithmetic mode, bitwise ops in logic mode.
module alu_1bit
    import alu_pkg::*;
(
    alu_serial_ctrl_if.slave bus
);

    logic b_eff;

    always_comb begin
        bus.alu_result = 1'b0;
        bus.alu_cout   = 1'b0;
        b_eff          = bus.alu_op2;
        if (!bus.alu_mode) begin
            if (bus.alu_opsel == ALU_SUB) b_eff = ~bus.alu_op2;
            bus.alu_result = bus.alu_op1 ^ b_eff ^ bus.alu_cin;
            bus.alu_cout   = (bus.alu_op1 & b_eff) | (bus.alu_op1 & bus.alu_cin)
                           | (b_eff & bus.alu_cin);
        end else begin
            // Logic ops generate no carry; the chain still runs but carries zero.
            case (bus.alu_opsel)
                ALU_AND: bus.alu_result = bus.alu_op1 & bus.alu_op2;
                ALU_OR:  bus.alu_result = bus.alu_op1 | bus.alu_op2;
                ALU_XOR: bus.alu_result = bus.alu_op1 ^ bus.alu_op2;
                default: bus.alu_result = bus.alu_op1;
            endcase
        end
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial initiator for a 1-bit ALU slice: shifts operands out LSB first, chains carry,
// assembles the result word and registers C/Z/O/S flags together with the done pulse.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [2:0]         opsel,
    input  logic               mode,
    input  logic               cin,
    alu_serial_ctrl_if.master  slice,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               c_flag,
    output logic               z_flag,
    output logic               o_flag,
    output logic               s_flag
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    alu_ser_state_t   state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Only WIDTH-1 bits are kept: the newest slice bit is merged in on the fly.
    logic [WIDTH-2:0] r_sh;
    logic [WIDTH-1:0] r_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [2:0]       opsel_q;
    logic             mode_q;
    logic             run;

    assign run = (state == S_RUN);

    assign slice.alu_op1   = run & a_sh[0];
    assign slice.alu_op2   = run & b_sh[0];
    assign slice.alu_cin   = run & carry;
    assign slice.alu_opsel = run ? opsel_q : 3'd0;
    assign slice.alu_mode  = run & mode_q;

    assign r_next = {slice.alu_result, r_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            r_sh    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            opsel_q <= 3'd0;
            mode_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            c_flag  <= 1'b0;
            z_flag  <= 1'b0;
            o_flag  <= 1'b0;
            s_flag  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_RUN;
                        busy    <= 1'b1;
                        a_sh    <= op_a;
                        b_sh    <= op_b;
                        r_sh    <= '0;
                        carry   <= cin;
                        cnt     <= '0;
                        opsel_q <= opsel;
                        mode_q  <= mode;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    r_sh  <= r_next[WIDTH-1:1];
                    carry <= slice.alu_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // carry still holds the carry into the MSB at this edge.
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= r_next;
                        c_flag <= slice.alu_cout;
                        o_flag <= mode_q ? 1'b0 : (carry ^ slice.alu_cout);
                        s_flag <= r_next[WIDTH-1];
                        z_flag <= ~|r_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl driving one alu_1bit, against a word-level arithmetic model.
module tb_alu_serial_ctrl;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [2:0]   opsel = 3'd0;
    logic         mode = 1'b0;
    logic         cin = 1'b0;
    logic         busy, done, c_flag, z_flag, o_flag, s_flag;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    alu_serial_ctrl_if sbus();

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .opsel(opsel), .mode(mode), .cin(cin), .slice(sbus),
        .busy(busy), .done(done), .result(result),
        .c_flag(c_flag), .z_flag(z_flag), .o_flag(o_flag), .s_flag(s_flag)
    );

    alu_1bit u_slice (.bus(sbus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: returns {c, z, o, s, result}.
    function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op, input logic md, input logic ci);
        int mask, hmask, ai, bi, full, res, c, cm, o;
        mask  = (1 << W) - 1;
        hmask = (1 << (W - 1)) - 1;
        ai = int'(a);
        bi = int'(b);
        c = 0;
        o = 0;
        if (!md) begin
            if (op == ALU_SUB) bi = (~bi) & mask;
            full = ai + bi + int'(ci);
            res  = full & mask;
            c    = (full >> W) & 1;
            cm   = (((ai & hmask) + (bi & hmask) + int'(ci)) >> (W - 1)) & 1;
            o    = cm ^ c;
        end else begin
            case (op)
                ALU_AND: res = ai & bi;
                ALU_OR:  res = ai | bi;
                ALU_XOR: res = ai ^ bi;
                default: res = ai;
            endcase
        end
        return {c[0], (res == 0), o[0], res[W-1], res[W-1:0]};
    endfunction

    task automatic chk_flags(input string tag, input logic [W+3:0] exp);
        chk({tag, " result"}, 32'(result), 32'(exp[W-1:0]));
        chk({tag, " c"}, 32'(c_flag), 32'(exp[W+3]));
        chk({tag, " z"}, 32'(z_flag), 32'(exp[W+2]));
        chk({tag, " o"}, 32'(o_flag), 32'(exp[W+1]));
        chk({tag, " s"}, 32'(s_flag), 32'(exp[W]));
    endtask

    // One operation from the start edge (cycle 0) to cycle W+3; poke != 0 pulses start in that cycle.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic md, input logic ci, input int poke);
        logic [W+3:0] exp;
        int done_cnt, done_at;
        exp = model(a, b, op, md, ci);
        done_cnt = 0;
        done_at = -1;
        @(negedge clk);
        op_a = a; op_b = b; opsel = op; mode = md; cin = ci; start = 1'b1;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                op_a = ~a; op_b = b ^ 8'h5A; opsel = op ^ 3'd1; mode = ~md; cin = ~ci;
            end
            if (poke != 0 && k == poke) start = 1'b1;
            if (poke != 0 && k == poke + 1) start = 1'b0;
            chk($sformatf("%s busy c%0d", tag, k), 32'(busy), (k <= W) ? 32'd1 : 32'd0);
            if (done) begin
                done_cnt++;
                done_at = k;
                chk_flags(tag, exp);
                chk({tag, " slice idle"},
                    32'({sbus.alu_op1, sbus.alu_op2, sbus.alu_cin, sbus.alu_opsel, sbus.alu_mode}), 32'd0);
            end
        end
        chk({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, " done cycle"}, 32'(done_at), 32'(W + 1));
    endtask

    initial begin
        logic [W+3:0] e1, e2;
        int done_c [$];
        logic [W-1:0] ra, rb;
        logic [2:0] rop;
        logic rmd, rci;

        // Reset state
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk_flags("reset", '0);
        chk("reset slice", 32'({sbus.alu_op1, sbus.alu_op2, sbus.alu_cin, sbus.alu_opsel, sbus.alu_mode}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add_3c_45", 8'h3C, 8'h45, ALU_ADD, 1'b0, 1'b0, 0);

        // Reset mid-run: async reset in RUN cycle 4 clears everything, no done follows.
        @(negedge clk);
        op_a = 8'h12; op_b = 8'h34; opsel = ALU_ADD; mode = 1'b0; cin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk_flags("midrst", '0);
        chk("midrst slice", 32'({sbus.alu_op1, sbus.alu_op2, sbus.alu_cin, sbus.alu_opsel, sbus.alu_mode}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            chk($sformatf("midrst no done c%0d", k), 32'(done), 32'd0);
        end

        do_op("add_ff_01", 8'hFF, 8'h01, ALU_ADD, 1'b0, 1'b0, 0);
        do_op("xor_a5_a5", 8'hA5, 8'hA5, ALU_XOR, 1'b1, 1'b0, 4);

        // Back-to-back with start held high across the first DONE cycle.
        e1 = model(8'h01, 8'h01, ALU_ADD, 1'b0, 1'b0);
        e2 = model(8'h7F, 8'h01, ALU_ADD, 1'b0, 1'b0);
        @(negedge clk);
        op_a = 8'h01; op_b = 8'h01; opsel = ALU_ADD; mode = 1'b0; cin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 2 * W + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin op_a = 8'h7F; op_b = 8'h01; end
            if (k == W + 2) start = 1'b0;
            if (done) done_c.push_back(k);
            if (k == W + 1) chk_flags("b2b first", e1);
            if (k > W + 1 && k < 2 * W + 2)
                chk($sformatf("b2b hold c%0d", k), 32'(result), 32'(e1[W-1:0]));
            if (k == 2 * W + 2) chk_flags("b2b second", e2);
        end
        chk("b2b done count", 32'(done_c.size()), 32'd2);
        if (done_c.size() == 2) begin
            chk("b2b done1 cycle", 32'(done_c[0]), 32'(W + 1));
            chk("b2b done2 cycle", 32'(done_c[1]), 32'(2 * W + 2));
        end

        // Randomized operations.
        for (int n = 0; n < 24; n++) begin
            rmd = 1'($urandom_range(0, 1));
            if (rmd) rop = 3'(ALU_AND + 3'($urandom_range(0, 2)));
            else     rop = ($urandom_range(0, 1) != 0) ? ALU_SUB : ALU_ADD;
            rci = rmd ? 1'b0 : 1'($urandom_range(0, 1));
            ra  = W'($urandom);
            rb  = W'($urandom);
            do_op($sformatf("rnd%0d", n), ra, rb, rop, rmd, rci, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
